oqpsk_symbol_upsampler: RTL and testbench



---
 rtl/oqpsk_symbol_upsampler_pkg.sv | 18 +
 rtl/oqpsk_symbol_upsampler.sv | 127 ++++++++++++
 tb/tb_oqpsk_symbol_upsampler.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/oqpsk_symbol_upsampler_pkg.sv
// rtl/oqpsk_symbol_upsampler_pkg.sv - shared types and field helpers for the OQPSK symbol upsampler
package oqpsk_symbol_upsampler_pkg;

  // IDLE waits for a symbol, EMIT plays the held symbol out over all phases.
  typedef enum logic {
    UPS_IDLE = 1'b0,
    UPS_EMIT = 1'b1
  } upsampler_state_t;

  // The I level always sits in the low half of a symbol word.
  localparam int UPS_I_LSB = 0;

  // The Q level starts at the midpoint of the symbol word.
  function automatic int ups_q_lsb(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/oqpsk_symbol_upsampler.sv
// rtl/oqpsk_symbol_upsampler.sv - expands each {Q,I} symbol into SAMPLES_PER_SYMBOL output samples
module oqpsk_symbol_upsampler
  import oqpsk_symbol_upsampler_pkg::*;
#(
  parameter int SAMPLES_PER_SYMBOL     = 8,
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int ZERO_STUFF             = 1
) (
  input  logic                              aclk,
  input  logic                              sresetn,
  input  logic                              s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  output logic                              m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready,
  output logic                              underrun
);

  localparam int PW    = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam int HALF  = C_S00_AXIS_TDATA_WIDTH / 2;
  localparam int Q_LSB = ups_q_lsb(C_S00_AXIS_TDATA_WIDTH);
  localparam logic [PW-1:0] PHASE_LAST = PW'(SAMPLES_PER_SYMBOL - 1);

  upsampler_state_t                  state_q, state_d;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] sym_q, sym_d;
  logic                              last_q, last_d;
  logic [PW-1:0]                     phase_q, phase_d;
  logic                              in_burst_q, in_burst_d;
  logic                              underrun_q, underrun_d;

  logic                              emit;
  logic                              final_ph;
  logic                              in_hs;
  logic                              out_hs;
  logic [HALF-1:0]                   sym_i;
  logic [HALF-1:0]                   sym_q_lvl;

  // Output handshake view and the held sample, rebuilt from its I/Q fields.
  always_comb begin
    emit            = (state_q == UPS_EMIT);
    final_ph        = (phase_q == PHASE_LAST);
    sym_i           = sym_q[UPS_I_LSB +: HALF];
    sym_q_lvl       = sym_q[Q_LSB +: HALF];
    m00_axis_tvalid = emit;
    m00_axis_tlast  = emit && last_q && final_ph;
    s00_axis_tready = (state_q == UPS_IDLE) || (final_ph && m00_axis_tready);
    m00_axis_tdata  = '0;
    if (emit && ((ZERO_STUFF == 0) || (phase_q == '0))) begin
      m00_axis_tdata = {sym_q_lvl, sym_i};
    end
    in_hs    = s00_axis_tvalid && s00_axis_tready;
    out_hs   = m00_axis_tvalid && m00_axis_tready;
    underrun = underrun_q;
  end

  // Next-state logic: phase advance, back-to-back reload, drain to idle and starvation flag.
  always_comb begin
    state_d    = state_q;
    sym_d      = sym_q;
    last_d     = last_q;
    phase_d    = phase_q;
    in_burst_d = in_burst_q;
    underrun_d = underrun_q;
    case (state_q)
      UPS_IDLE: begin
        if (in_hs) begin
          state_d    = UPS_EMIT;
          sym_d      = s00_axis_tdata;
          last_d     = s00_axis_tlast;
          phase_d    = '0;
          in_burst_d = !s00_axis_tlast;
        end
      end
      UPS_EMIT: begin
        if (out_hs) begin
          if (!final_ph) begin
            phase_d = phase_q + PW'(1);
          end else begin
            if (last_q) begin
              in_burst_d = 1'b0;
            end
            phase_d = '0;
            if (in_hs) begin
              sym_d      = s00_axis_tdata;
              last_d     = s00_axis_tlast;
              in_burst_d = !s00_axis_tlast;
            end else begin
              state_d = UPS_IDLE;
              // The next symbol of an open burst did not arrive in time.
              if (!last_q) begin
                underrun_d = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        state_d = UPS_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset drops any symbol in flight.
  always_ff @(posedge aclk) begin
    if (!sresetn) begin
      state_q    <= UPS_IDLE;
      sym_q      <= '0;
      last_q     <= 1'b0;
      phase_q    <= '0;
      in_burst_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_q      <= sym_d;
      last_q     <= last_d;
      phase_q    <= phase_d;
      in_burst_q <= in_burst_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_oqpsk_symbol_upsampler.sv
// tb/tb_oqpsk_symbol_upsampler.sv - scoreboard bench for the OQPSK symbol upsampler
module tb_oqpsk_symbol_upsampler;

  localparam int SPS = 8;
  localparam int W   = 32;

  logic         aclk = 1'b0;
  logic         sresetn;
  logic         s_tvalid;
  logic [W-1:0] s_tdata;
  logic         s_tlast;
  logic         m_tready;

  logic         s_tready_a, m_tvalid_a, m_tlast_a, underrun_a;
  logic [W-1:0] m_tdata_a;
  logic         s_tready_b, m_tvalid_b, m_tlast_b, underrun_b;
  logic [W-1:0] m_tdata_b;

  typedef struct {
    logic [W-1:0] sym;
    logic         last;
    int           phase;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   hs_cnt = 0;
  int   last_hs_cyc = 0;
  int   base;
  exp_t e;

  oqpsk_symbol_upsampler #(
    .SAMPLES_PER_SYMBOL(SPS), .C_S00_AXIS_TDATA_WIDTH(W),
    .C_M00_AXIS_TDATA_WIDTH(W), .ZERO_STUFF(1)
  ) dut_zs (
    .aclk(aclk), .sresetn(sresetn),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast),
    .s00_axis_tready(s_tready_a),
    .m00_axis_tvalid(m_tvalid_a), .m00_axis_tdata(m_tdata_a), .m00_axis_tlast(m_tlast_a),
    .m00_axis_tready(m_tready), .underrun(underrun_a)
  );

  oqpsk_symbol_upsampler #(
    .SAMPLES_PER_SYMBOL(SPS), .C_S00_AXIS_TDATA_WIDTH(W),
    .C_M00_AXIS_TDATA_WIDTH(W), .ZERO_STUFF(0)
  ) dut_hold (
    .aclk(aclk), .sresetn(sresetn),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast),
    .s00_axis_tready(s_tready_b),
    .m00_axis_tvalid(m_tvalid_b), .m00_axis_tdata(m_tdata_b), .m00_axis_tlast(m_tlast_b),
    .m00_axis_tready(m_tready), .underrun(underrun_b)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Drive one symbol and hold it until accepted; queue its expected samples.
  task automatic send(input logic [W-1:0] d, input logic l);
    int waited = 0;
    @(negedge aclk);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    #1;
    while (!s_tready_a && waited < 50) begin
      @(negedge aclk);
      #1;
      waited++;
    end
    if (waited >= 50) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_timeout: observed tready low for %0d cycles expected acceptance", waited);
      s_tvalid = 1'b0;
    end else begin
      for (int p = 0; p < SPS; p++) begin
        e.sym   = d;
        e.last  = l;
        e.phase = p;
        sb.push_back(e);
      end
    end
    @(posedge aclk);
  endtask

  task automatic idle_in();
    @(negedge aclk);
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((sb.size() != 0 || m_tvalid_a) && k < budget) begin
      @(negedge aclk);
      #3;
      k++;
    end
    if (k >= budget) begin
      n_cmp++;
      n_err++;
      $error("FAIL drain_timeout: observed %0d samples pending expected 0", sb.size());
    end
  endtask

  // Output monitor: every accepted sample is checked against the scoreboard head.
  initial begin
    exp_t m;
    forever begin
      @(negedge aclk);
      #2;
      if (sresetn && m_tvalid_a && m_tready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL unexpected_sample: observed %h expected no sample", m_tdata_a);
        end else begin
          m = sb.pop_front();
          chk("zs_tdata", m_tdata_a, (m.phase == 0) ? m.sym : '0);
          chk("hold_tdata", m_tdata_b, m.sym);
          chk("zs_tlast", {31'b0, m_tlast_a}, {31'b0, m.last && (m.phase == SPS - 1)});
          chk("hold_tlast", {31'b0, m_tlast_b}, {31'b0, m.last && (m.phase == SPS - 1)});
          chk("s_tready_phase", {31'b0, s_tready_a}, {31'b0, m.phase == SPS - 1});
          chk("hold_tvalid", {31'b0, m_tvalid_b}, 32'd1);
          hs_cnt++;
          last_hs_cyc = cyc;
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #300000;
    $error("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    // Reset values.
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_tvalid", {31'b0, m_tvalid_a}, 32'd0);
    chk("rst_tdata", m_tdata_a, '0);
    chk("rst_tlast", {31'b0, m_tlast_a}, 32'd0);
    chk("rst_tready", {31'b0, s_tready_a}, 32'd1);
    chk("rst_underrun", {31'b0, underrun_a}, 32'd0);
    @(negedge aclk);
    sresetn = 1'b1;
    #1;
    chk("post_rst_tready", {31'b0, s_tready_b}, 32'd1);

    // Single zero-stuffed symbol.
    send(32'h0001_FFFF, 1'b1);
    idle_in();
    drain(40);
    chk("single_underrun", {31'b0, underrun_a}, 32'd0);

    // Four-symbol burst with tvalid held: 32 samples and no bubbles.
    base = hs_cnt;
    send(32'h1234_5678, 1'b0);
    send(32'h8000_7FFF, 1'b0);
    send(32'hFFFF_0000, 1'b0);
    send(32'h0F0F_F0F0, 1'b1);
    idle_in();
    drain(80);
    chk("burst_count", hs_cnt - base, 32);
    chk("burst_span", last_hs_cyc - hs_cyc[base], 31);
    chk("burst_underrun", {31'b0, underrun_b}, 32'd0);

    // Downstream stall at phase 3 for five cycles.
    send(32'hA5A5_5A5A, 1'b1);
    idle_in();
    repeat (2) @(negedge aclk);
    @(negedge aclk);
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_tvalid", {31'b0, m_tvalid_a}, 32'd1);
      chk("stall_zs_tdata", m_tdata_a, '0);
      chk("stall_hold_tdata", m_tdata_b, 32'hA5A5_5A5A);
      chk("stall_tlast", {31'b0, m_tlast_a}, 32'd0);
      chk("stall_s_tready", {31'b0, s_tready_a}, 32'd0);
      @(negedge aclk);
    end
    m_tready = 1'b1;
    drain(40);

    // Two single-symbol bursts back to back.
    base = hs_cnt;
    send(32'h7FFF_8001, 1'b1);
    send(32'h0000_0001, 1'b1);
    idle_in();
    drain(60);
    chk("b2b_count", hs_cnt - base, 16);
    chk("b2b_span", last_hs_cyc - hs_cyc[base], 15);

    // Mid-burst starvation.
    send(32'h4444_3333, 1'b0);
    idle_in();
    drain(40);
    #1;
    chk("starve_underrun_a", {31'b0, underrun_a}, 32'd1);
    chk("starve_underrun_b", {31'b0, underrun_b}, 32'd1);
    chk("starve_idle_tready", {31'b0, s_tready_a}, 32'd1);
    repeat (3) @(negedge aclk);
    #1;
    chk("starve_sticky", {31'b0, underrun_a}, 32'd1);
    chk("starve_tvalid", {31'b0, m_tvalid_a}, 32'd0);

    // Reset asserted at phase 5 for one cycle.
    send(32'hBEEF_CAFE, 1'b1);
    idle_in();
    repeat (5) @(negedge aclk);
    sresetn = 1'b0;
    @(negedge aclk);
    sresetn = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_tvalid", {31'b0, m_tvalid_a}, 32'd0);
    chk("mid_rst_tlast", {31'b0, m_tlast_a}, 32'd0);
    chk("mid_rst_tready", {31'b0, s_tready_a}, 32'd1);
    chk("mid_rst_underrun", {31'b0, underrun_a}, 32'd0);

    // Recovery after reset.
    send(32'h0102_0304, 1'b1);
    idle_in();
    drain(40);
    chk("final_queue", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
